// File: rtl/image_loader_pkg.sv
// Shared constants and state encoding for the image loader and the conv engine.
package image_loader_pkg;

    localparam int unsigned IMG_H = 28;
    localparam int unsigned IMG_W = 28;
    localparam int unsigned NPIX  = IMG_H * IMG_W;
    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_CONV = 2'd2
    } state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream handshake between a pixel source and the image loader.
interface image_loader_if;
    import image_loader_pkg::*;

    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_last;
    logic             s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/image_loader_ram.sv
// Simple dual-port frame RAM: one write, one registered read-first read.
module image_ram #(
    parameter int unsigned DEPTH  = 784,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Array read; the non-blocking write above makes a same-address read return old data.
    always_comb begin
        rd_data_d = mem[raddr];
    end

    // Registered read output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/image_loader.sv
// Frame writer: stores one raster frame, starts the conv engine, waits for it to finish.
module image_loader
    import image_loader_pkg::*;
#(
    parameter int unsigned H      = IMG_H,
    parameter int unsigned W      = IMG_W,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    image_loader_if.slave     s_if,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              err_len,
    input  logic              clr_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned       FRAME_PIX = H * W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
    logic                err_len_q,   err_len_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                wr_en;

    // Next-state, write address, error and frame-count logic.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        err_len_d   = err_len_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;

        // Clear first so that any error set below wins.
        if (clr_err) begin
            err_len_d = 1'b0;
        end

        case (state_q)
            LOAD: begin
                if (s_if.s_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        state_d   = START;
                        if (!s_if.s_last) begin
                            err_len_d = 1'b1;
                        end
                    end else if (s_if.s_last) begin
                        // Short frame: drop it and restart at address 0.
                        err_len_d = 1'b1;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            START: begin
                state_d = WAIT_CONV;
            end
            WAIT_CONV: begin
                if (conv_done) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    state_d     = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_addr_q   <= '0;
            err_len_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            err_len_q   <= err_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_if.s_ready = (state_q == LOAD);
    assign conv_start   = (state_q == START);
    assign busy         = (state_q != LOAD);
    assign err_len      = err_len_q;
    assign frame_cnt    = frame_cnt_q;

    image_ram #(
        .DEPTH  (FRAME_PIX),
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en & ~rst),
        .waddr (wr_addr_q),
        .wdata (s_if.s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: full frame, hold-off, short/long frames, reset, counter wrap.
module tb_image_loader;
    import image_loader_pkg::*;

    localparam int unsigned AW  = 10;
    localparam int unsigned FW  = 8;
    localparam int unsigned AW2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main 28x28 instance.
    image_loader_if s_if ();
    logic           conv_start, conv_done, busy, err_len, clr_err;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data;
    logic [FW-1:0]  frame_cnt;

    // Small 2x2 instance for the frame-counter wrap.
    image_loader_if s2_if ();
    logic           conv_start2, conv_done2, busy2, err_len2, clr_err2;
    logic [AW2-1:0] rd_addr2;
    logic [7:0]     rd_data2;
    logic [FW-1:0]  frame_cnt2;

    int total = 0;
    int bad   = 0;
    int start_cnt  = 0;
    int start_cnt2 = 0;

    image_loader #(.H(28), .W(28), .ADDR_W(AW), .FCNT_W(FW)) dut (
        .clk(clk), .rst(rst), .s_if(s_if), .conv_start(conv_start), .conv_done(conv_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err_len(err_len),
        .clr_err(clr_err), .frame_cnt(frame_cnt)
    );

    image_loader #(.H(2), .W(2), .ADDR_W(AW2), .FCNT_W(FW)) dut2 (
        .clk(clk), .rst(rst), .s_if(s2_if), .conv_start(conv_start2), .conv_done(conv_done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .err_len(err_len2),
        .clr_err(clr_err2), .frame_cnt(frame_cnt2)
    );

    // Count start pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (conv_start === 1'b1)  start_cnt++;
        if (conv_start2 === 1'b1) start_cnt2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream pixels first..last_excl-1 with value (i+seed), s_last on index last_idx.
    task automatic send_pixels(input int first, input int last_excl, input int seed, input int last_idx);
        for (int i = first; i < last_excl; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = 8'(i + seed);
            s_if.s_last  = (i == last_idx);
            tick();
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic pulse_done();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (s_if.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_if.s_ready); end
        total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL reset_conv_start: got %b want 0", conv_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err_len: got %b want 0", err_len); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        total++; if (frame_cnt2 !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt2: got %0d want 0", frame_cnt2); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int s0;
        s0 = start_cnt;
        send_pixels(0, 783, 0, -1);
        total++; if (start_cnt != s0 || s_if.s_ready !== 1'b1) begin bad++; $display("FAIL full_pre_last: starts=%0d ready=%b want 0,1", start_cnt - s0, s_if.s_ready); end
        send_pixels(783, 784, 0, 783);
        total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL full_start_latency: got %b want 1", conv_start); end
        total++; if (s_if.s_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %b want 0", s_if.s_ready); end
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL full_err_len: got %b want 0", err_len); end
        rd_addr = 10'h1F5;
        tick();
        total++; if (conv_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full_start_width: start=%b busy=%b want 0,1", conv_start, busy); end
        total++; if (rd_data !== 8'hF5) begin bad++; $display("FAIL full_read_1f5: got %h want f5", rd_data); end
        rd_addr = 10'd783;
        tick();
        total++; if (rd_data !== 8'h0F) begin bad++; $display("FAIL full_read_783: got %h want 0f", rd_data); end
        total++; if (start_cnt != s0 + 1) begin bad++; $display("FAIL full_start_count: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_backpressure();
        int not_ready;
        not_ready = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'hAA;
        s_if.s_last  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_if.s_ready === 1'b0 && busy === 1'b1) not_ready++;
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        total++; if (not_ready != 100) begin bad++; $display("FAIL hold_ready_low: got %0d cycles want 100", not_ready); end
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL hold_err_len: got %b want 0", err_len); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            tick();
            total++; if (rd_data !== 8'(a)) begin bad++; $display("FAIL hold_ram_%0d: got %h want %h", a, rd_data, 8'(a)); end
        end
        pulse_done();
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL hold_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (s_if.s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_release: ready=%b busy=%b want 1,0", s_if.s_ready, busy); end
    endtask

    task automatic test_short_frame();
        int s0;
        s0 = start_cnt;
        send_pixels(0, 2, 8'h40, -1);
        // Write addr 2 while reading it: old frame value 0x02 must come back.
        rd_addr = 10'd2;
        send_pixels(2, 3, 8'h40, -1);
        total++; if (rd_data !== 8'h02) begin bad++; $display("FAIL read_first_old: got %h want 02", rd_data); end
        tick();
        total++; if (rd_data !== 8'h42) begin bad++; $display("FAIL read_after_write: got %h want 42", rd_data); end
        send_pixels(3, 11, 8'h40, 10);
        tick();
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL short_err_len: got %b want 1", err_len); end
        total++; if (start_cnt != s0 || s_if.s_ready !== 1'b1) begin bad++; $display("FAIL short_no_start: starts=%0d ready=%b want 0,1", start_cnt - s0, s_if.s_ready); end
        send_pixels(0, 783, 8'h80, -1);
        total++; if (start_cnt != s0) begin bad++; $display("FAIL short_restart_addr: got %0d starts want 0", start_cnt - s0); end
        send_pixels(783, 784, 8'h80, 783);
        total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL short_next_start: got %b want 1", conv_start); end
        rd_addr = 10'd0;
        tick();
        total++; if (rd_data !== 8'h80) begin bad++; $display("FAIL short_next_addr0: got %h want 80", rd_data); end
        rd_addr = 10'd10;
        tick();
        total++; if (rd_data !== 8'h8A) begin bad++; $display("FAIL short_next_addr10: got %h want 8a", rd_data); end
        pulse_done();
        total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL short_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_missing_last();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL clr_err_clears: got %b want 0", err_len); end
        send_pixels(0, 784, 1, -1);
        total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL nolast_start: got %b want 1", conv_start); end
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL nolast_err_len: got %b want 1", err_len); end
        tick();
        pulse_done();
        total++; if (frame_cnt !== 8'd3) begin bad++; $display("FAIL nolast_frame_cnt: got %0d want 3", frame_cnt); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL clr_err_again: got %b want 0", err_len); end
        // Short-frame error and clr_err on the same edge: set wins.
        send_pixels(0, 2, 0, -1);
        clr_err = 1'b1;
        send_pixels(2, 3, 0, 2);
        clr_err = 1'b0;
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL set_beats_clr: got %b want 1", err_len); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = start_cnt;
        send_pixels(0, 400, 8'h10, -1);
        rst = 1'b1;
        tick();
        total++; if (s_if.s_ready !== 1'b1 || busy !== 1'b0 || conv_start !== 1'b0) begin bad++; $display("FAIL midrst_ctrl: ready=%b busy=%b start=%b want 1,0,0", s_if.s_ready, busy, conv_start); end
        total++; if (frame_cnt !== 8'd0 || err_len !== 1'b0) begin bad++; $display("FAIL midrst_regs: cnt=%0d err=%b want 0,0", frame_cnt, err_len); end
        rst = 1'b0;
        tick();
        tick();
        send_pixels(0, 783, 8'h20, -1);
        total++; if (start_cnt != s0) begin bad++; $display("FAIL midrst_addr_zero: got %0d starts want 0", start_cnt - s0); end
        send_pixels(783, 784, 8'h20, 783);
        total++; if (conv_start !== 1'b1 || err_len !== 1'b0) begin bad++; $display("FAIL midrst_frame: start=%b err=%b want 1,0", conv_start, err_len); end
        rd_addr = 10'd399;
        tick();
        total++; if (rd_data !== 8'hAF) begin bad++; $display("FAIL midrst_read399: got %h want af", rd_data); end
        pulse_done();
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); end
        // conv_done in LOAD is ignored.
        pulse_done();
        total++; if (frame_cnt !== 8'd1 || s_if.s_ready !== 1'b1) begin bad++; $display("FAIL done_in_load: cnt=%0d ready=%b want 1,1", frame_cnt, s_if.s_ready); end
    endtask

    task automatic test_frame_wrap();
        int s0;
        s0 = start_cnt2;
        conv_done2 = 1'b1;
        tick();
        conv_done2 = 1'b0;
        total++; if (frame_cnt2 !== 8'd0) begin bad++; $display("FAIL wrap_done_in_load: got %0d want 0", frame_cnt2); end
        for (int f = 0; f < 256; f++) begin
            for (int p = 0; p < 4; p++) begin
                s2_if.s_valid = 1'b1;
                s2_if.s_data  = 8'(p + f);
                s2_if.s_last  = (p == 3);
                tick();
            end
            s2_if.s_valid = 1'b0;
            s2_if.s_last  = 1'b0;
            tick();
            conv_done2 = 1'b1;
            tick();
            conv_done2 = 1'b0;
            if (f == 254) begin
                total++; if (frame_cnt2 !== 8'd255) begin bad++; $display("FAIL wrap_cnt_255: got %0d want 255", frame_cnt2); end
            end
        end
        total++; if (frame_cnt2 !== 8'd0) begin bad++; $display("FAIL wrap_cnt_0: got %0d want 0", frame_cnt2); end
        total++; if (start_cnt2 != s0 + 256 || err_len2 !== 1'b0) begin bad++; $display("FAIL wrap_starts: got %0d err=%b want 256,0", start_cnt2 - s0, err_len2); end
    endtask

    initial begin
        rst           = 1'b1;
        s_if.s_valid  = 1'b0;
        s_if.s_data   = 8'd0;
        s_if.s_last   = 1'b0;
        conv_done     = 1'b0;
        clr_err       = 1'b0;
        rd_addr       = '0;
        s2_if.s_valid = 1'b0;
        s2_if.s_data  = 8'd0;
        s2_if.s_last  = 1'b0;
        conv_done2    = 1'b0;
        clr_err2      = 1'b0;
        rd_addr2      = '0;

        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_missing_last();
        test_reset_mid();
        test_frame_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
